// File: rtl/mc_wb_ctrl.sv
// mc_wb_ctrl -- multi-cycle MIPS controller sequencing IF/ID/EX/MEM/WB with
// one instruction in flight. Drives the write-back select (ALU output vs LMD),
// the register-file write and PC update strobes, and runs a ready/timeout
// handshake with data memory.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           leave IDLE and begin fetching
//   op_code         opcode from IR, captured at the end of ID
//   zero            ALU zero flag, used in EX for BEQ
//   mem_ready       data memory done (read valid / write accepted)
//   if_en, pc_wr    IR load and PC write strobes
//   pc_sel          00 PC+4, 01 branch target, 10 jump target
//   ex_en           ALU stage / ALUOutput load enable
//   mem_rd, mem_wr  data memory requests, held until mem_ready or timeout
//   wb_sel, reg_wr  write-back select (1 = LMD) and register-file write
//   state           current state code (debug)
//   err             00 none, 01 illegal opcode, 10 memory timeout
//
// Optional feature: define MC_WB_CTRL_PERF_EN to add the 32-bit cyc_cnt
// (active cycles) and instr_cnt (completed instructions) outputs.

module mc_wb_ctrl #(
  parameter int MEM_TIMEOUT = 15,  // 1..255
  parameter int OP_W        = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [OP_W-1:0] op_code,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            if_en,
  output logic            pc_wr,
  output logic [1:0]      pc_sel,
  output logic            ex_en,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            wb_sel,
  output logic            reg_wr,
  output logic [2:0]      state,
  output logic [1:0]      err
`ifdef MC_WB_CTRL_PERF_EN
  ,
  output logic [31:0]     cyc_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_R   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b000010);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t          st, nxt;
  logic [OP_W-1:0] opc_q, opc_n;
  logic [7:0]      wcnt, wcnt_n;
  logic [1:0]      err_n;
  logic            pc_wr_q;

  function automatic logic is_legal(input logic [OP_W-1:0] o);
    return (o == OP_R) || (o == OP_LW) || (o == OP_SW) ||
           (o == OP_BEQ) || (o == OP_J);
  endfunction

  // Opcode as it will be seen next cycle; lets the registered strobes for EX
  // and MEM be decoded on the same edge the opcode register loads.
  assign opc_n = (st == S_ID) ? op_code : opc_q;

  always_comb begin
    nxt    = st;
    err_n  = err;
    wcnt_n = wcnt;
    case (st)
      S_IDLE: if (start) nxt = S_IF;
      S_IF:   nxt = S_ID;
      S_ID: begin
        if (!is_legal(op_code)) begin
          nxt   = S_HALT;
          err_n = ERR_ILL;
        end else if (op_code == OP_J) begin
          nxt = S_IF;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        if (opc_q == OP_R) begin
          nxt = S_WB;
        end else if (opc_q == OP_LW || opc_q == OP_SW) begin
          nxt    = S_MEM;
          wcnt_n = '0;
        end else if (opc_q == OP_BEQ) begin
          nxt = S_IF;
        end else begin
          nxt   = S_HALT;
          err_n = ERR_ILL;
        end
      end
      S_MEM: begin
        // Ready in the first request cycle counts, so zero-wait memory works.
        if (mem_ready) begin
          nxt = (opc_q == OP_LW) ? S_WB : S_IF;
        end else if (wcnt == TMO_LAST) begin
          nxt   = S_HALT;
          err_n = ERR_TMO;
        end else begin
          wcnt_n = wcnt + 8'd1;
        end
      end
      S_WB:   nxt = S_IF;
      S_HALT: nxt = S_HALT;
      default: begin
        nxt   = S_HALT;
        err_n = ERR_ILL;
      end
    endcase
  end

  // State plus strobes registered from the next state, so strobes are glitch
  // free and requests drop on the same edge that leaves MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= S_IDLE;
      opc_q   <= '0;
      wcnt    <= '0;
      err     <= ERR_NONE;
      if_en   <= 1'b0;
      pc_wr_q <= 1'b0;
      ex_en   <= 1'b0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      reg_wr  <= 1'b0;
      wb_sel  <= 1'b0;
    end else begin
      st      <= nxt;
      opc_q   <= opc_n;
      wcnt    <= wcnt_n;
      err     <= err_n;
      if_en   <= (nxt == S_IF);
      pc_wr_q <= (nxt == S_IF);
      ex_en   <= (nxt == S_EX);
      mem_rd  <= (nxt == S_MEM) && (opc_n == OP_LW);
      mem_wr  <= (nxt == S_MEM) && (opc_n == OP_SW);
      reg_wr  <= (nxt == S_WB);
      // wb_sel only moves on WB entry and holds otherwise
      if (nxt == S_WB) wb_sel <= (opc_n == OP_LW);
    end
  end

  // Jump and branch PC updates depend on op_code/zero inside the cycle
  // itself, so they are decoded from the current state.
  logic jmp, br_sel;
  assign jmp    = (st == S_ID) && (op_code == OP_J);
  assign br_sel = (st == S_EX) && (opc_q == OP_BEQ);
  assign pc_wr  = pc_wr_q | jmp | (br_sel & zero);
  assign pc_sel = jmp ? 2'b10 : (br_sel ? 2'b01 : 2'b00);
  assign state  = st;

`ifdef MC_WB_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      if (st != S_IDLE && st != S_HALT) cyc_cnt <= cyc_cnt + 32'd1;
      // IF entry from any later stage marks a completed instruction
      if ((st == S_ID || st == S_EX || st == S_MEM || st == S_WB) && nxt == S_IF)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_wb_ctrl.sv
// tb_mc_wb_ctrl -- randomized self-checking bench for mc_wb_ctrl. The model
// walks each instruction as a list of pipeline phases and derives the
// expected strobes per phase from the opcode rules; don't-care inputs are
// randomized every cycle.

module tb_mc_wb_ctrl;
  localparam int TMO = 15;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic       clk = 1'b0;
  logic       rst, start, zero, mem_ready;
  logic [5:0] op_code;
  logic       if_en, pc_wr, ex_en, mem_rd, mem_wr, wb_sel, reg_wr;
  logic [1:0] pc_sel, err;
  logic [2:0] state;
`ifdef MC_WB_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  int checks = 0, errors = 0;
  logic       m_wb_sel;
  logic [1:0] m_err;
  logic [31:0] m_cyc, m_ins;

  always #5 clk = ~clk;

  mc_wb_ctrl #(.MEM_TIMEOUT(TMO), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op_code(op_code), .zero(zero),
    .mem_ready(mem_ready), .if_en(if_en), .pc_wr(pc_wr), .pc_sel(pc_sel),
    .ex_en(ex_en), .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_sel(wb_sel),
    .reg_wr(reg_wr), .state(state), .err(err)
`ifdef MC_WB_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  wire [13:0] obs = {if_en, pc_wr, pc_sel, ex_en, mem_rd, mem_wr, wb_sel,
                     reg_wr, state, err};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask

  // expected output vector for one phase; wb_sel and err come from model state
  function automatic logic [13:0] ev(input logic [2:0] st, input logic ife,
      input logic pcw, input logic [1:0] pcs, input logic exe, input logic rd,
      input logic wr, input logic rw);
    return {ife, pcw, pcs, exe, rd, wr, m_wb_sel, rw, st, m_err};
  endfunction

  task automatic expc(input string tag, input logic [13:0] e, input bit last);
    chk(tag, 32'(obs), 32'(e));
`ifdef MC_WB_CTRL_PERF_EN
    chk({tag, "_cyc"}, cyc_cnt, m_cyc);
    chk({tag, "_ins"}, instr_cnt, m_ins);
`endif
    if (e[4:2] != 3'd0 && e[4:2] != 3'd6) m_cyc++;
    if (last) m_ins++;
  endtask

  // advance one cycle and scramble the inputs the DUT should ignore
  task automatic tick(input bit rnd_start);
    @(posedge clk);
    #1;
    start     = rnd_start ? 1'($urandom) : 1'b0;
    op_code   = 6'($urandom);
    zero      = 1'($urandom);
    mem_ready = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    m_err = 2'b00; m_wb_sel = 1'b0; m_cyc = 0; m_ins = 0;
    #1 expc("reset", ev(3'd0, 0, 0, 2'b00, 0, 0, 0, 0), 0);
  endtask

  task automatic idle_hold(input int n);
    repeat (n) begin
      tick(0);
      #1 expc("idle", ev(3'd0, 0, 0, 2'b00, 0, 0, 0, 0), 0);
    end
  endtask

  task automatic launch();
    tick(0);
    start = 1'b1;
    #1 expc("idle_go", ev(3'd0, 0, 0, 2'b00, 0, 0, 0, 0), 0);
  endtask

  task automatic halt_hold(input string tag, input int n);
    repeat (n) begin
      tick(1);
      #1 expc(tag, ev(3'd6, 0, 0, 2'b00, 0, 0, 0, 0), 0);
    end
  endtask

  // One instruction from IF; waits<0 means memory never answers.
  task automatic do_instr(input logic [5:0] opc, input logic z, input int waits,
                          output bit halted);
    bit legal, is_lw, is_sw;
    halted = 0;
    legal = (opc == OP_R) || (opc == OP_LW) || (opc == OP_SW) ||
            (opc == OP_BEQ) || (opc == OP_J);
    is_lw = (opc == OP_LW);
    is_sw = (opc == OP_SW);
    tick(1);
    #1 expc("IF", ev(3'd1, 1, 1, 2'b00, 0, 0, 0, 0), 0);
    tick(1);
    op_code = opc;
    #1;
    if (opc == OP_J) begin
      expc("ID_J", ev(3'd2, 0, 1, 2'b10, 0, 0, 0, 0), 1);
      return;
    end
    expc("ID", ev(3'd2, 0, 0, 2'b00, 0, 0, 0, 0), 0);
    if (!legal) begin
      m_err = 2'b01; halted = 1;
      halt_hold("HALT_ill", 20);
      return;
    end
    tick(1);
    zero = z;
    #1;
    if (opc == OP_BEQ) begin
      expc("EX_BEQ", ev(3'd3, 0, z, 2'b01, 1, 0, 0, 0), 1);
      return;
    end
    expc("EX", ev(3'd3, 0, 0, 2'b00, 1, 0, 0, 0), 0);
    if (is_lw || is_sw) begin
      for (int k = 0; k < TMO; k++) begin
        tick(1);
        mem_ready = (k == waits);
        #1 expc("MEM", ev(3'd4, 0, 0, 2'b00, 0, is_lw, is_sw, 0), (k == waits) && is_sw);
        if (k == waits) break;
        if (k == TMO - 1) begin
          m_err = 2'b10; halted = 1;
          halt_hold("HALT_tmo", 3);
          return;
        end
      end
      if (is_sw) return;
    end
    tick(1);
    m_wb_sel = is_lw;
    #1 expc("WB", ev(3'd5, 0, 0, 2'b00, 0, 0, 0, 1), 1);
  endtask

  // SW with reset landing in the second MEM cycle
  task automatic sw_rst();
    bit h;
    do_instr(OP_R, 1'b0, 0, h);
    tick(1);
    #1 expc("IF_r", ev(3'd1, 1, 1, 2'b00, 0, 0, 0, 0), 0);
    tick(1); op_code = OP_SW;
    #1 expc("ID_r", ev(3'd2, 0, 0, 2'b00, 0, 0, 0, 0), 0);
    tick(1);
    #1 expc("EX_r", ev(3'd3, 0, 0, 2'b00, 1, 0, 0, 0), 0);
    tick(1); mem_ready = 1'b0;
    #1 expc("MEM1_r", ev(3'd4, 0, 0, 2'b00, 0, 0, 1, 0), 0);
    tick(1); mem_ready = 1'b0; rst = 1'b1;
    #1 expc("MEM2_r", ev(3'd4, 0, 0, 2'b00, 0, 0, 1, 0), 0);
    tick(0); rst = 1'b0;
    m_err = 2'b00; m_wb_sel = 1'b0; m_cyc = 0; m_ins = 0;
    #1 expc("rst_mem", ev(3'd0, 0, 0, 2'b00, 0, 0, 0, 0), 0);
  endtask

  initial begin
    bit h;
    logic [5:0] o;
    int r, w;
    rst = 1'b1; start = 1'b0; op_code = '0; zero = 1'b0; mem_ready = 1'b0;
    m_err = 2'b00; m_wb_sel = 1'b0; m_cyc = 0; m_ins = 0;
    do_reset();
    idle_hold(10);
    launch();
    do_instr(OP_R, 1'b0, 0, h);
    do_instr(OP_LW, 1'b0, 3, h);
    do_instr(OP_BEQ, 1'b1, 0, h);
    do_instr(OP_BEQ, 1'b0, 0, h);
    do_instr(OP_J, 1'b0, 0, h);
    do_instr(OP_SW, 1'b0, 0, h);
    do_instr(OP_LW, 1'b0, 0, h);
    do_instr(OP_R, 1'b0, 0, h);
    do_instr(6'b111111, 1'b0, 0, h);
    do_reset();
    launch();
    do_instr(OP_SW, 1'b0, -1, h);
    do_reset();
    launch();
    sw_rst();
    launch();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      w = $urandom_range(0, 4);
      case (r)
        0, 1: o = OP_R;
        2, 3: o = OP_LW;
        4, 5: o = OP_SW;
        6:    o = OP_BEQ;
        7:    o = OP_J;
        8: begin
          o = 6'($urandom);
          while (o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_J)
            o = 6'($urandom);
        end
        default: begin
          o = ($urandom % 2) ? OP_LW : OP_SW;
          w = -1;
        end
      endcase
      do_instr(o, 1'($urandom), w, h);
      if (h) begin
        do_reset();
        idle_hold(2);
        launch();
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
